// File: rtl/axis_packet_splitter_pkg.sv
// Shared types for the packet splitter: FSM state encoding and a log2 helper.
// Define USE_ONE_HOT_ENCODING_FSM for one-hot state encoding.
package axis_packet_splitter_pkg;

`ifdef USE_ONE_HOT_ENCODING_FSM
   typedef enum logic [4:0] {
      STR = 5'b00001,
      OPE = 5'b00010,
      DRN = 5'b00100,
      ERR = 5'b01000,
      END = 5'b10000
   } state_e;
`else
   typedef enum logic [2:0] {
      STR = 3'd0,
      OPE = 3'd1,
      DRN = 3'd2,
      ERR = 3'd3,
      END = 3'd4
   } state_e;
`endif

   function automatic int log2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_packet_splitter_lsb_onehot_select.sv
// Combinational lowest-set-bit picker: one-hot grant, binary index and any-bit-set flag.
module lsb_onehot_select #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     mask,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   assign grant = mask & (~mask + N'(1));
   assign vld   = |mask;

   // Scan downwards so the lowest set bit is the one that sticks.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/axis_packet_splitter.sv
// Deals one AXI-Stream packet across CHANNELS outputs (len[c] beats each, lowest enabled first); zero-latency path,
// s_axis_tready mirrors the selected channel's tready. Define AXIS_SPLITTER_TLAST_CHECK_EN to police input tlast.
module axis_packet_splitter
   import axis_packet_splitter_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int DATA_WIDTH  = 16,
   parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
   parameter bit USER_ENABLE = 1'b0,
   parameter int USER_WIDTH  = USER_ENABLE ? 8 : 1,
   parameter int LEN_WIDTH   = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           operation_start,
   input  logic [CHANNELS-1:0]            use_channels,
   input  logic [CHANNELS*LEN_WIDTH-1:0]  channel_len,
   input  logic                           interrupt,
   output logic                           operation_busy,
   output logic                           operation_complete,
   output logic                           operation_error,
   output logic                           transmission,
   input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   input  logic [USER_WIDTH-1:0]          s_axis_tuser,
   output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
   output logic [CHANNELS*KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic [CHANNELS*USER_WIDTH-1:0] m_axis_tuser,
   output logic [CHANNELS-1:0]            m_axis_tlast,
   output logic [CHANNELS-1:0]            m_axis_tvalid,
   input  logic [CHANNELS-1:0]            m_axis_tready
);

   localparam int IDX_W = log2_min1(CHANNELS);

   state_e                              state_q, state_d;
   logic [CHANNELS-1:0]                 mask_q, mask_d;
   logic [LEN_WIDTH-1:0]                cnt_q, cnt_d;
   logic [CHANNELS-1:0][LEN_WIDTH-1:0]  len_q, len_d;
   logic                                transmission_q, transmission_d;

   logic [CHANNELS-1:0][LEN_WIDTH-1:0]  start_len;
   logic [CHANNELS-1:0]                 cur_grant, nxt_grant, start_grant, nxt_mask;
   logic [IDX_W-1:0]                    cur_idx, nxt_idx, start_idx;
   logic                                cur_vld, nxt_vld, start_vld;
   logic                                lens_ok, hs, last_of_ch, final_beat, tlast_in;
   logic                                unused_sel;

   assign start_len = channel_len;
   assign nxt_mask  = mask_q & ~cur_grant;

   lsb_onehot_select #(.N(CHANNELS), .IDX_W(IDX_W)) u_sel_cur (
      .mask(mask_q), .grant(cur_grant), .idx(cur_idx), .vld(cur_vld)
   );
   lsb_onehot_select #(.N(CHANNELS), .IDX_W(IDX_W)) u_sel_nxt (
      .mask(nxt_mask), .grant(nxt_grant), .idx(nxt_idx), .vld(nxt_vld)
   );
   lsb_onehot_select #(.N(CHANNELS), .IDX_W(IDX_W)) u_sel_start (
      .mask(use_channels), .grant(start_grant), .idx(start_idx), .vld(start_vld)
   );

`ifdef AXIS_SPLITTER_TLAST_CHECK_EN
   assign tlast_in = s_axis_tlast;
`else
   assign tlast_in = 1'b0;
`endif

   assign unused_sel = ^{start_grant, nxt_grant, cur_idx, cur_vld, s_axis_tlast};

   always_comb begin
      lens_ok = 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
         if (use_channels[c] && (start_len[c] == '0)) lens_ok = 1'b0;
      end
   end

   assign last_of_ch = (cnt_q == LEN_WIDTH'(1));
   assign final_beat = last_of_ch && !nxt_vld;
   assign hs         = s_axis_tvalid && s_axis_tready;

   // An early input tlast is still marked on the output so the lane sees a closed packet.
   always_comb begin
      m_axis_tvalid = '0;
      m_axis_tlast  = '0;
      s_axis_tready = 1'b0;
      if (!interrupt) begin
         if (state_q == OPE) begin
            m_axis_tvalid = cur_grant & {CHANNELS{s_axis_tvalid}};
            m_axis_tlast  = cur_grant & {CHANNELS{last_of_ch | tlast_in}};
            s_axis_tready = |(m_axis_tready & cur_grant);
         end else if (state_q == DRN) begin
            s_axis_tready = 1'b1;
         end
      end
   end

   assign m_axis_tdata = {CHANNELS{s_axis_tdata}};
   assign m_axis_tkeep = KEEP_ENABLE ? {CHANNELS{s_axis_tkeep}} : '1;
   assign m_axis_tuser = USER_ENABLE ? {CHANNELS{s_axis_tuser}} : '0;

   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      cnt_d          = cnt_q;
      len_d          = len_q;
      transmission_d = hs;
      if (interrupt) begin
         state_d = STR;
         mask_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            STR, END: begin
               state_d = STR;
               if (operation_start) begin
                  if (start_vld && lens_ok) begin
                     state_d = OPE;
                     mask_d  = use_channels;
                     len_d   = start_len;
                     cnt_d   = start_len[start_idx];
                  end else begin
                     state_d = ERR;
                  end
               end
            end
            OPE: begin
               if (hs) begin
                  if (last_of_ch) begin
                     mask_d = nxt_mask;
                     cnt_d  = nxt_vld ? len_q[nxt_idx] : '0;
                  end else begin
                     cnt_d = cnt_q - LEN_WIDTH'(1);
                  end
`ifdef AXIS_SPLITTER_TLAST_CHECK_EN
                  if (s_axis_tlast && !final_beat) state_d = ERR;
                  else if (final_beat)             state_d = s_axis_tlast ? END : DRN;
`else
                  if (final_beat) state_d = END;
`endif
               end
            end
            DRN: begin
               if (s_axis_tvalid && s_axis_tlast) state_d = ERR;
            end
            ERR: begin
               state_d = STR;
               mask_d  = '0;
               cnt_d   = '0;
            end
            default: state_d = STR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= STR;
         mask_q         <= '0;
         cnt_q          <= '0;
         len_q          <= '0;
         transmission_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         mask_q         <= mask_d;
         cnt_q          <= cnt_d;
         len_q          <= len_d;
         transmission_q <= transmission_d;
      end
   end

   assign operation_busy     = (state_q == OPE) || (state_q == DRN);
   assign operation_complete = (state_q == END);
   assign operation_error    = (state_q == ERR);
   assign transmission       = transmission_q;

endmodule

// File: tb/tb_axis_packet_splitter.sv
// Randomised bench for axis_packet_splitter against a beat-list reference model, plus literal pins per scenario.
module tb_axis_packet_splitter;

   localparam int CH = 3;
   localparam int DW = 16;
   localparam int KW = 2;
   localparam int UW = 1;
   localparam int LW = 16;
`ifdef AXIS_SPLITTER_TLAST_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            operation_start = 1'b0;
   logic            interrupt = 1'b0;
   logic [CH-1:0]   use_channels = '0;
   logic [CH*LW-1:0] channel_len = '0;
   logic            operation_busy, operation_complete, operation_error, transmission;
   logic [DW-1:0]   s_axis_tdata = '0;
   logic [KW-1:0]   s_axis_tkeep = '0;
   logic            s_axis_tvalid = 1'b0;
   logic            s_axis_tready;
   logic            s_axis_tlast = 1'b0;
   logic [UW-1:0]   s_axis_tuser = '0;
   logic [CH*DW-1:0] m_axis_tdata;
   logic [CH*KW-1:0] m_axis_tkeep;
   logic [CH*UW-1:0] m_axis_tuser;
   logic [CH-1:0]   m_axis_tlast, m_axis_tvalid;
   logic [CH-1:0]   m_axis_tready = '0;

   axis_packet_splitter #(
      .CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_ENABLE(1'b1), .KEEP_WIDTH(KW),
      .USER_ENABLE(1'b0), .USER_WIDTH(UW), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .operation_start(operation_start), .use_channels(use_channels),
      .channel_len(channel_len), .interrupt(interrupt),
      .operation_busy(operation_busy), .operation_complete(operation_complete),
      .operation_error(operation_error), .transmission(transmission),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
   );

   int n_chk = 0;
   int n_pass = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
   endfunction

   // Reference model: the packet as an ordered list of (channel, last) beats.
   typedef enum {P_IDLE, P_ACT, P_DRN} phase_t;
   phase_t ph = P_IDLE;
   bit e_complete = 0, e_error = 0, e_tx = 0;
   int exp_ch[$];
   bit exp_last[$];
   int k = 0;

   logic [DW-1:0] sdata[$];
   bit            slast[$];
   int            di = 0;
   bit            hs_seen = 0;
   bit            done_flag = 0;

   int cyc_n = 0, busy_cyc, cmpl_cnt, err_cnt, rdy_cyc, hs_cnt, last_hs_cyc, cmpl_cyc;
   int beats_ch[CH], last_ch[CH], vld_ch[CH];

   always @(negedge clk) begin
      logic [CH-1:0] e_vld;
      logic          e_rdy, e_lst, hs, fin, ok;
      int            ch, len;
      bit            nc, ne;
      e_vld = '0; e_rdy = 1'b0; ch = 0; nc = 0; ne = 0;
      cyc_n++;
      if (!rst_n) begin
         ph = P_IDLE; e_complete = 0; e_error = 0; e_tx = 0; k = 0;
         chk("rst_tvalid", m_axis_tvalid, '0);
         chk("rst_tready", s_axis_tready, 0);
         chk("rst_busy", operation_busy, 0);
         chk("rst_pulses", {operation_complete, operation_error, transmission}, 0);
         hs_seen = 0;
      end else begin
         if (ph == P_ACT && k < exp_ch.size()) ch = exp_ch[k];
         if (!interrupt) begin
            if (ph == P_ACT) begin
               e_rdy = m_axis_tready[ch];
               if (s_axis_tvalid) e_vld[ch] = 1'b1;
            end else if (ph == P_DRN) begin
               e_rdy = 1'b1;
            end
         end
         chk("s_tready", s_axis_tready, e_rdy);
         chk("m_tvalid", m_axis_tvalid, e_vld);
         chk("busy", operation_busy, ph != P_IDLE);
         chk("complete", operation_complete, e_complete);
         chk("error", operation_error, e_error);
         chk("transmission", transmission, e_tx);
         if (e_vld != '0) begin
            e_lst = exp_last[k] | (CHECK_EN & s_axis_tlast);
            chk("m_tdata", m_axis_tdata[ch*DW +: DW], sdata[k]);
            chk("m_tkeep", m_axis_tkeep[ch*KW +: KW], s_axis_tkeep);
            chk("m_tlast", m_axis_tlast, e_lst ? e_vld : '0);
         end

         // Observed DUT activity, for the literal per-scenario pins.
         hs_seen = s_axis_tvalid && s_axis_tready;
         if (hs_seen) begin hs_cnt++; last_hs_cyc = cyc_n; end
         if (operation_busy) busy_cyc++;
         if (s_axis_tready) rdy_cyc++;
         if (operation_complete) begin cmpl_cnt++; cmpl_cyc = cyc_n; end
         if (operation_error) err_cnt++;
         if (operation_complete || operation_error) done_flag = 1;
         for (int c = 0; c < CH; c++) begin
            if (m_axis_tvalid[c]) vld_ch[c]++;
            if (m_axis_tvalid[c] && m_axis_tready[c]) begin
               beats_ch[c]++;
               if (m_axis_tlast[c]) last_ch[c]++;
            end
         end

         hs = s_axis_tvalid && e_rdy;
         if (interrupt) begin
            ph = P_IDLE;
         end else begin
            case (ph)
               P_IDLE: if (operation_start && !e_error) begin
                  ok = (use_channels != '0);
                  for (int c = 0; c < CH; c++)
                     if (use_channels[c] && channel_len[c*LW +: LW] == '0) ok = 0;
                  if (ok) begin
                     exp_ch.delete(); exp_last.delete();
                     for (int c = 0; c < CH; c++) begin
                        len = int'(channel_len[c*LW +: LW]);
                        if (use_channels[c])
                           for (int b = 0; b < len; b++) begin
                              exp_ch.push_back(c);
                              exp_last.push_back(b == len - 1);
                           end
                     end
                     k = 0; ph = P_ACT;
                  end else ne = 1;
               end
               P_ACT: if (hs) begin
                  fin = (k == exp_ch.size() - 1);
                  if (CHECK_EN && s_axis_tlast && !fin) begin ne = 1; ph = P_IDLE; end
                  else if (fin) begin
                     if (!CHECK_EN || s_axis_tlast) begin nc = 1; ph = P_IDLE; end
                     else ph = P_DRN;
                  end
                  k++;
               end
               P_DRN: if (hs && s_axis_tlast) begin ne = 1; ph = P_IDLE; end
               default: ph = P_IDLE;
            endcase
         end
         e_complete = nc; e_error = ne; e_tx = hs;
      end
   end

   task automatic step(input int vp, input int rp);
      @(posedge clk); #1;
      if (hs_seen) di++;
      s_axis_tvalid = (di < sdata.size()) && ($urandom_range(99) < vp);
      if (di < sdata.size()) begin
         s_axis_tdata = sdata[di];
         s_axis_tlast = slast[di];
      end
      s_axis_tkeep = KW'($urandom);
      for (int c = 0; c < CH; c++) m_axis_tready[c] = ($urandom_range(99) < rp);
   endtask

   task automatic run_op(input logic [CH-1:0] mask, input int l0, input int l1, input int l2,
                         input int tl_at, input int vp, input int rp, input int intr_at, input int rst_at);
      int n, nb;
      int lens[CH];
      lens[0] = l0; lens[1] = l1; lens[2] = l2;
      n = 0;
      for (int c = 0; c < CH; c++) if (mask[c]) n += lens[c];
      if (tl_at < 0) tl_at = n - 1;
      nb = (tl_at + 1 > n) ? tl_at + 1 : n;
      if (nb < 1) nb = 1;
      sdata.delete(); slast.delete();
      for (int i = 0; i < nb; i++) begin
         sdata.push_back(DW'($urandom));
         slast.push_back(i == tl_at);
      end
      di = 0; hs_seen = 0; done_flag = 0;
      busy_cyc = 0; cmpl_cnt = 0; err_cnt = 0; rdy_cyc = 0; hs_cnt = 0; last_hs_cyc = 0; cmpl_cyc = 0;
      for (int c = 0; c < CH; c++) begin beats_ch[c] = 0; last_ch[c] = 0; vld_ch[c] = 0; end
      use_channels = mask;
      channel_len = {LW'(l2), LW'(l1), LW'(l0)};
      step(vp, rp);
      operation_start = 1'b1;
      step(vp, rp);
      operation_start = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (done_flag) break;
         if (cyc == intr_at) interrupt = 1'b1;
         if (cyc == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("async_rst_tvalid", m_axis_tvalid, '0);
            chk("async_rst_tready", s_axis_tready, 0);
         end
         step(vp, rp);
         interrupt = 1'b0;
         rst_n = 1'b1;
         if ((intr_at >= 0 && cyc >= intr_at) || (rst_at >= 0 && cyc >= rst_at)) break;
      end
      repeat (3) step(0, 100);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Two channels, 2 then 3 beats, no backpressure.
      run_op(3'b011, 2, 3, 0, -1, 100, 100, -1, -1);
      chk("t1_done", done_flag, 1);
      chk("t1_beats0", beats_ch[0], 2);
      chk("t1_beats1", beats_ch[1], 3);
      chk("t1_lasts", {last_ch[1][3:0], last_ch[0][3:0]}, 8'h11);
      chk("t1_busy_cycles", busy_cyc, 5);
      chk("t1_complete_cnt", cmpl_cnt, 1);
      chk("t1_complete_delay", cmpl_cyc - last_hs_cyc, 1);

      // Skipped middle channel, single-beat first channel.
      run_op(3'b101, 1, 0, 4, -1, 100, 100, -1, -1);
      chk("t2_ch1_never_valid", vld_ch[1], 0);
      chk("t2_beats", {beats_ch[2][3:0], beats_ch[1][3:0], beats_ch[0][3:0]}, 12'h401);
      chk("t2_lasts", {last_ch[2][3:0], last_ch[0][3:0]}, 8'h11);
      chk("t2_busy_cycles", busy_cyc, 5);

      // Bad configurations.
      run_op(3'b000, 1, 1, 1, -1, 100, 100, -1, -1);
      chk("t3_err_cnt", err_cnt, 1);
      chk("t3_busy_cycles", busy_cyc, 0);
      chk("t3_ready_cycles", rdy_cyc, 0);
      run_op(3'b011, 2, 0, 3, -1, 100, 100, -1, -1);
      chk("t3b_err_cnt", err_cnt, 1);
      chk("t3b_busy_cycles", busy_cyc, 0);
      chk("t3b_ready_cycles", rdy_cyc, 0);

      // Random backpressure on both sides.
      run_op(3'b011, 5, 7, 0, -1, 60, 50, -1, -1);
      chk("t4_done", done_flag, 1);
      chk("t4_beats0", beats_ch[0], 5);
      chk("t4_beats1", beats_ch[1], 7);
      chk("t4_complete_cnt", cmpl_cnt, 1);

      // Input tlast on beat 3 of 5, then input tlast missing at packet end.
      run_op(3'b011, 2, 3, 0, 2, 100, 100, -1, -1);
`ifdef AXIS_SPLITTER_TLAST_CHECK_EN
      chk("t5_err_cnt", err_cnt, 1);
      chk("t5_complete_cnt", cmpl_cnt, 0);
      chk("t5_ch1_tlast", last_ch[1], 1);
      chk("t5_ch1_beats", beats_ch[1], 1);
      run_op(3'b011, 2, 3, 0, 7, 100, 100, -1, -1);
      chk("t5b_err_cnt", err_cnt, 1);
      chk("t5b_hs_cnt", hs_cnt, 8);
      chk("t5b_out_beats", beats_ch[0] + beats_ch[1], 5);
`else
      chk("t5_complete_cnt", cmpl_cnt, 1);
      chk("t5_err_cnt", err_cnt, 0);
      chk("t5_beats1", beats_ch[1], 3);
`endif

      // Interrupt after two beats, then a clean restart.
      run_op(3'b011, 3, 3, 0, -1, 100, 100, 2, -1);
      chk("t6_busy_after", operation_busy, 0);
      chk("t6_beats0", beats_ch[0], 2);
      chk("t6_no_pulses", cmpl_cnt + err_cnt, 0);
      run_op(3'b011, 2, 3, 0, -1, 100, 100, -1, -1);
      chk("t6_restart_complete", cmpl_cnt, 1);

      // Async reset mid-packet, then a clean restart.
      run_op(3'b011, 3, 3, 0, -1, 100, 100, -1, 2);
      chk("t7_busy_after", operation_busy, 0);
      run_op(3'b110, 0, 2, 2, -1, 80, 80, -1, -1);
      chk("t7_restart_complete", cmpl_cnt, 1);

      for (int r = 0; r < 25; r++) begin
         int l0, l1, l2;
         logic [CH-1:0] m;
         m = CH'($urandom_range(1, 7));
         l0 = $urandom_range(1, 5); l1 = $urandom_range(1, 5); l2 = $urandom_range(1, 5);
         run_op(m, l0, l1, l2, -1, $urandom_range(30, 100), $urandom_range(30, 100), -1, -1);
         chk("rand_done", done_flag, 1);
         chk("rand_complete", cmpl_cnt, 1);
         chk("rand_total_beats", beats_ch[0] + beats_ch[1] + beats_ch[2],
             (m[0] ? l0 : 0) + (m[1] ? l1 : 0) + (m[2] ? l2 : 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
